output_shifter: RTL and testbench
=================================

Name: output_shifter

Overview:
Downstream stage of the output register. It takes the processor's parallel output image (`outputNumber` bits) at each scan-end request and shifts it MSB-first into external serial-in/parallel-out driver latches (74HC595-style). It then pulses the storage latch so the physical outputs update together once per scan. It also keeps a copy of the image last committed to the pins.

Parameters:
OUT_NUM, 8, number of output bits shifted per frame; equals `outputNumber`
CLK_DIV, 4, system-clock cycles per half period of sClk; legal range 1..255
CNT_W, 8, width of the divider counter; must satisfy 2^CNT_W > CLK_DIV

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-low reset
outputs  input  OUT_NUM  parallel output image from the output register
scanEnd  input  1  single-cycle request to commit the current image
busy  output  1  high while a frame is shifting or latching
sClk  output  1  serial shift clock to the external driver
sData  output  1  serial data, MSB first
sLatch  output  1  storage-latch strobe to the external driver
done  output  1  one-cycle pulse when a frame has been latched
image  output  OUT_NUM  image last latched to the pins

Behaviour:
- Reset is asynchronous and active-low. While reset=0: state=IDLE; sClk=0, sData=0, sLatch=0, busy=0, done=0, image=0; pending flag, bit counter and divider counter are all cleared.
- Reset asserted mid-frame aborts the frame immediately. No latch pulse is issued and image is not updated.
- The FSM has three states: IDLE, SHIFT, LATCH.
- IDLE:
  - On scanEnd=1, or with pending=1: capture outputs into the shift register, clear pending, set bitCnt=OUT_NUM-1, set busy=1, go to SHIFT.
  - The first sData value (captured bit OUT_NUM-1) appears the cycle after capture.
- SHIFT: each bit takes 2*CLK_DIV cycles.
  - First half: sClk=0 and sData holds the current bit.
  - Second half: sClk=1.
  - On the last cycle of the high half: sClk returns to 0, the register shifts left, and bitCnt decrements.
  - After bit 0 completes: go to LATCH. sData goes to 0.
- LATCH:
  - sLatch=1 for CLK_DIV cycles. image is loaded from the captured frame on the first LATCH cycle.
  - On exit: sLatch=0, done=1 for exactly one cycle, busy=0, return to IDLE.
- Frame latency: scanEnd to done is 1 + 2*CLK_DIV*OUT_NUM + CLK_DIV cycles. With defaults that is 69.
- scanEnd while busy=1 sets pending. Pending is one deep, so further requests during the same frame are merged.
  - When a pending frame starts, outputs are sampled at that time, not at request time.
  - The pending frame starts in the cycle after done. busy drops for that one cycle only.
- scanEnd in the same cycle as done also sets pending.
- outputs may change at any time while busy. The captured frame is unaffected.
- sClk, sData and sLatch are registered outputs and must be glitch-free. sData only changes while sClk=0.
- Counters wrap only by explicit reload. bitCnt never underflows.

Test Plan:
- Reset: hold reset=0 with outputs=8'hFF and scanEnd pulsed -> all outputs 0, no sClk edges; after release, outputs stay idle until scanEnd.
- Single frame: outputs=8'hA5, one scanEnd pulse, CLK_DIV=4 -> 8 sClk rising edges; sData at each rising edge is 1,0,1,0,0,1,0,1; sLatch high for 4 cycles; image=8'hA5; done asserted 69 cycles after scanEnd.
- Capture isolation: scanEnd with 8'h3C, then change outputs to 8'hFF during SHIFT -> shifted bits 0,0,1,1,1,1,0,0; image=8'h3C.
- Pending merge: three scanEnd pulses during one frame, outputs=8'h0F at its done -> exactly one extra frame; it starts one cycle after done and ends with image=8'h0F; no third frame.
- Abort: assert reset during bit 3 of a frame for 8'h81 -> sLatch never pulses, image stays 0, busy=0 immediately.
- CLK_DIV=1, OUT_NUM=4: outputs=4'b1001 -> sClk toggles every cycle, done at cycle 1+8+1=10, image=4'b1001.

Source files
------------

// File: rtl/output_shifter_if.sv
// rtl/output_shifter_if.sv - output image / serial driver bundle for output_shifter
interface output_shifter_if #(
   parameter int OUT_NUM = 8
);
   logic [OUT_NUM-1:0] outputs;
   logic               scanEnd;
   logic               busy;
   logic               sClk;
   logic               sData;
   logic               sLatch;
   logic               done;
   logic [OUT_NUM-1:0] image;

   modport master (
      output outputs, scanEnd,
      input  busy, sClk, sData, sLatch, done, image
   );

   modport slave (
      input  outputs, scanEnd,
      output busy, sClk, sData, sLatch, done, image
   );
endinterface

// File: rtl/output_shifter.sv
// rtl/output_shifter.sv - shifts the output image MSB-first into 595-style latches once per scan
module output_shifter #(
   parameter int OUT_NUM = 8,
   parameter int CLK_DIV = 4,
   parameter int CNT_W   = 8
) (
   input  logic             clk,
   input  logic             reset,
   output_shifter_if.slave  bus
);
   localparam int BIT_W = (OUT_NUM > 1) ? $clog2(OUT_NUM) : 1;
   localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_TOP  = BIT_W'(OUT_NUM - 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      LATCH
   } state_t;

   state_t             state_q, state_d;
   logic [OUT_NUM-1:0] shift_q, shift_d;
   logic [OUT_NUM-1:0] frame_q, frame_d;
   logic [OUT_NUM-1:0] image_q, image_d;
   logic [BIT_W-1:0]   bit_q, bit_d;
   logic [CNT_W-1:0]   div_q, div_d;
   logic               pend_q, pend_d;
   logic               busy_q, busy_d;
   logic               sclk_q, sclk_d;
   logic               sdata_q, sdata_d;
   logic               slatch_q, slatch_d;
   logic               done_q, done_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         shift_q  <= '0;
         frame_q  <= '0;
         image_q  <= '0;
         bit_q    <= '0;
         div_q    <= '0;
         pend_q   <= 1'b0;
         busy_q   <= 1'b0;
         sclk_q   <= 1'b0;
         sdata_q  <= 1'b0;
         slatch_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         frame_q  <= frame_d;
         image_q  <= image_d;
         bit_q    <= bit_d;
         div_q    <= div_d;
         pend_q   <= pend_d;
         busy_q   <= busy_d;
         sclk_q   <= sclk_d;
         sdata_q  <= sdata_d;
         slatch_q <= slatch_d;
         done_q   <= done_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      frame_d  = frame_q;
      image_d  = image_q;
      bit_d    = bit_q;
      div_d    = div_q;
      pend_d   = pend_q;
      sclk_d   = sclk_q;
      sdata_d  = sdata_q;
      slatch_d = slatch_q;
      done_d   = 1'b0;

      case (state_q)
         IDLE: begin
            // A request arriving in the done cycle starts here directly, same edge as a pending start.
            if (bus.scanEnd || pend_q) begin
               shift_d = bus.outputs;
               frame_d = bus.outputs;
               pend_d  = 1'b0;
               bit_d   = BIT_TOP;
               div_d   = '0;
               sclk_d  = 1'b0;
               sdata_d = bus.outputs[OUT_NUM-1];
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (bus.scanEnd) pend_d = 1'b1;
            if (div_q == DIV_LAST) begin
               div_d = '0;
               if (!sclk_q) begin
                  sclk_d = 1'b1;
               end else begin
                  // Falling edge of sClk: data moves only here, so it is stable at every rise.
                  sclk_d  = 1'b0;
                  shift_d = shift_q << 1;
                  sdata_d = shift_d[OUT_NUM-1];
                  if (bit_q == '0) begin
                     sdata_d  = 1'b0;
                     slatch_d = 1'b1;
                     image_d  = frame_q;
                     state_d  = LATCH;
                  end else begin
                     bit_d = bit_q - 1'b1;
                  end
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         LATCH: begin
            if (bus.scanEnd) pend_d = 1'b1;
            if (div_q == DIV_LAST) begin
               div_d    = '0;
               slatch_d = 1'b0;
               done_d   = 1'b1;
               state_d  = IDLE;
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   assign bus.busy   = busy_q;
   assign bus.sClk   = sclk_q;
   assign bus.sData  = sdata_q;
   assign bus.sLatch = slatch_q;
   assign bus.done   = done_q;
   assign bus.image  = image_q;
endmodule

// File: tb/tb_output_shifter.sv
// tb/tb_output_shifter.sv - directed bench for output_shifter at 8x/div4 and 4x/div1
module tb_output_shifter;
   logic clk = 1'b0;
   logic reset = 1'b0;

   always #5 clk = ~clk;

   output_shifter_if #(.OUT_NUM(8)) ia ();
   output_shifter_if #(.OUT_NUM(4)) ib ();

   output_shifter #(.OUT_NUM(8), .CLK_DIV(4), .CNT_W(8)) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (ia)
   );

   output_shifter #(.OUT_NUM(4), .CLK_DIV(1), .CNT_W(8)) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (ib)
   );

   int n_chk = 0;
   int n_bad = 0;

   int       rise_a, lat_a, busy_a;
   logic [7:0] bits_a;
   logic     prev_a;
   int       rise_b, lat_b, tog_b;
   logic [3:0] bits_b;
   logic     prev_b;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_mon();
      rise_a = 0; lat_a = 0; busy_a = 0; bits_a = '0;
      rise_b = 0; lat_b = 0; tog_b = 0; bits_b = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (ia.sClk && !prev_a) begin
         rise_a++;
         bits_a = {bits_a[6:0], ia.sData};
      end
      if (ia.sLatch) lat_a++;
      if (ia.busy) busy_a++;
      prev_a = ia.sClk;
      if (ib.sClk && !prev_b) begin
         rise_b++;
         bits_b = {bits_b[2:0], ib.sData};
      end
      if (ib.sClk != prev_b) tog_b++;
      if (ib.sLatch) lat_b++;
      prev_b = ib.sClk;
   endtask

   task automatic wait_done_a(inout int cyc);
      while (!ia.done && cyc < 300) begin
         tick();
         cyc++;
      end
   endtask

   task automatic start_a(input logic [7:0] val, output int cyc);
      ia.outputs = val;
      ia.scanEnd = 1'b1;
      tick();
      ia.scanEnd = 1'b0;
      cyc = 1;
   endtask

   initial begin
      int cyc;
      prev_a = 1'b0;
      prev_b = 1'b0;
      clear_mon();
      ib.outputs = '0;
      ib.scanEnd = 1'b0;

      // reset held with activity on the inputs
      ia.outputs = 8'hFF;
      ia.scanEnd = 1'b1;
      repeat (5) tick();
      check("rst_busy", ia.busy, 0);
      check("rst_sclk", ia.sClk, 0);
      check("rst_sdata", ia.sData, 0);
      check("rst_slatch", ia.sLatch, 0);
      check("rst_done", ia.done, 0);
      check("rst_image", ia.image, 0);
      check("rst_rises", rise_a, 0);
      ia.scanEnd = 1'b0;
      reset = 1'b1;
      repeat (10) tick();
      check("idle_busy", busy_a, 0);
      check("idle_rises", rise_a, 0);

      // single frame 8'hA5
      clear_mon();
      start_a(8'hA5, cyc);
      wait_done_a(cyc);
      check("a5_latency", cyc, 69);
      check("a5_rises", rise_a, 8);
      check("a5_bits", bits_a, 8'hA5);
      check("a5_latch_cycles", lat_a, 4);
      check("a5_image", ia.image, 8'hA5);
      check("a5_busy_at_done", ia.busy, 0);
      tick();
      check("a5_done_width", ia.done, 0);

      // capture isolation
      repeat (3) tick();
      clear_mon();
      start_a(8'h3C, cyc);
      repeat (10) begin tick(); cyc++; end
      ia.outputs = 8'hFF;
      wait_done_a(cyc);
      check("iso_bits", bits_a, 8'h3C);
      check("iso_image", ia.image, 8'h3C);
      check("iso_latency", cyc, 69);

      // pending merge
      repeat (3) tick();
      clear_mon();
      start_a(8'h55, cyc);
      while (!ia.done && cyc < 300) begin
         ia.scanEnd = (cyc == 10 || cyc == 20 || cyc == 30);
         if (cyc == 40) ia.outputs = 8'h0F;
         tick();
         cyc++;
      end
      ia.scanEnd = 1'b0;
      check("pend_first_latency", cyc, 69);
      check("pend_first_bits", bits_a, 8'h55);
      check("pend_busy_gap", ia.busy, 0);
      clear_mon();
      tick();
      cyc = 1;
      check("pend_restart_busy", ia.busy, 1);
      wait_done_a(cyc);
      check("pend_second_latency", cyc, 69);
      check("pend_second_rises", rise_a, 8);
      check("pend_second_bits", bits_a, 8'h0F);
      check("pend_second_image", ia.image, 8'h0F);
      clear_mon();
      repeat (150) tick();
      check("pend_no_third_busy", busy_a, 0);
      check("pend_no_third_rises", rise_a, 0);

      // abort during bit 3
      clear_mon();
      start_a(8'h81, cyc);
      while (rise_a < 5 && cyc < 300) begin
         tick();
         cyc++;
      end
      check("abort_reached_bit3", rise_a, 5);
      reset = 1'b0;
      #1;
      check("abort_busy", ia.busy, 0);
      check("abort_sclk", ia.sClk, 0);
      check("abort_slatch", ia.sLatch, 0);
      repeat (3) tick();
      reset = 1'b1;
      clear_mon();
      repeat (100) tick();
      check("abort_no_latch", lat_a, 0);
      check("abort_image", ia.image, 0);
      check("abort_idle", busy_a, 0);

      // narrow instance: 4 bits, divide by 1
      clear_mon();
      ib.outputs = 4'b1001;
      ib.scanEnd = 1'b1;
      tick();
      ib.scanEnd = 1'b0;
      cyc = 1;
      while (!ib.done && cyc < 100) begin
         tick();
         cyc++;
      end
      check("b_latency", cyc, 10);
      check("b_rises", rise_b, 4);
      check("b_toggles", tog_b, 8);
      check("b_bits", bits_b, 4'b1001);
      check("b_latch_cycles", lat_b, 1);
      check("b_image", ib.image, 4'b1001);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
